addsub_serial_arbiter: RTL and testbench

- Shares one 4-bit add/subtract slice between two requesters.
- Operands are WIDTH bits wide; the block walks them nibble-by-nibble, LSB first, through the slice.
- A registered carry links nibbles; the final result returns on a valid/ready response channel.
- Sits between requesting datapath blocks and the shared arithmetic resource.

---
 rtl/addsub_serial_arbiter.sv | 132 +++++++++++++
 tb/tb_addsub_serial_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial_arbiter.sv
// Two-requester arbiter in front of one shared 4-bit add/subtract slice.
// Operands are processed one nibble per cycle, LSB first, with a registered carry.
module addsub_serial_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             busy
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] a_r, b_r, res_r, res_nxt;
  logic             op_r, id_r, carry_r, ptr_r;
  logic [CW-1:0]    cnt_r;
  logic             gnt0, gnt1, accept, last_nib;
  logic [3:0]       a_nib, b_nib;
  logic [4:0]       sum5;
  logic [3:0]       low3;
  logic             c_msb_in;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)    next_state = RUN;
      RUN:     if (last_nib)  next_state = DONE;
      DONE:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Grant and handshake outputs; ptr_r=0 favours requester 0 on a tie
  always_comb begin
    gnt0       = req0_valid & (~req1_valid | ~ptr_r);
    gnt1       = req1_valid & ~gnt0;
    req0_ready = (state == IDLE) & gnt0;
    req1_ready = (state == IDLE) & gnt1;
    accept     = req0_ready | req1_ready;
    last_nib   = (state == RUN) && (cnt_r == CW'(NIB - 1));
  end

  // Shared slice: the bit-2 carry is kept separately to form the MSB overflow
  always_comb begin
    a_nib    = a_r[{cnt_r, 2'b00} +: 4];
    b_nib    = b_r[{cnt_r, 2'b00} +: 4] ^ {4{op_r}};
    sum5     = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_r};
    low3     = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry_r};
    c_msb_in = low3[3];
    res_nxt  = res_r;
    res_nxt[{cnt_r, 2'b00} +: 4] = sum5[3:0];
  end

  // Operand latch, nibble walk and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      res_r     <= '0;
      op_r      <= 1'b0;
      id_r      <= 1'b0;
      carry_r   <= 1'b0;
      ptr_r     <= 1'b0;
      cnt_r     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_s     <= '0;
      rsp_cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            a_r     <= gnt1 ? req1_a : req0_a;
            b_r     <= gnt1 ? req1_b : req0_b;
            op_r    <= gnt1 ? req1_op : req0_op;
            carry_r <= gnt1 ? req1_op : req0_op;
            id_r    <= gnt1;
            ptr_r   <= gnt0;
            cnt_r   <= '0;
            res_r   <= '0;
          end
        end
        RUN: begin
          res_r   <= res_nxt;
          carry_r <= sum5[4];
          cnt_r   <= cnt_r + CW'(1);
          if (last_nib) begin
            rsp_s     <= res_nxt;
            rsp_cout  <= sum5[4];
            rsp_ovf   <= c_msb_in ^ sum5[4];
            rsp_id    <= id_r;
            rsp_valid <= 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial_arbiter.sv
// Directed bench for addsub_serial_arbiter (WIDTH=16): arithmetic, latency,
// round-robin arbitration, response backpressure and mid-operation reset.
module tb_addsub_serial_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_op;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_op;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf, busy;
  logic [15:0] rsp_s;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  addsub_serial_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_s(rsp_s),
    .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  task automatic apply_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = 1'b0;
    req1_a = '0; req1_b = '0; req1_op = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issue one operation on a single requester; returns latency (accept edge = 1) and the response.
  task automatic do_op(input logic id, input logic [15:0] a, input logic [15:0] b, input logic op,
                       output int lat, output logic [15:0] s, output logic c, output logic v,
                       output logic rid);
    int t;
    if (id) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
    #1;
    t = 0;
    while (!(id ? req1_ready : req0_ready) && t < 20) begin @(posedge clk); #1; t++; end
    if (t >= 20) begin
      lat = 99;
    end else begin
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = 16'hDEAD; req1_a = 16'hBEEF;
      lat = 1;
      while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    end
    s = rsp_s; c = rsp_cout; v = rsp_ovf; rid = rsp_id;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    #3;
    total++;
    if ({rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_ovf, busy, req0_ready, req1_ready} !== 23'd0)
      $display("FAIL reset_values: got valid=%b id=%b s=%h cout=%b ovf=%b busy=%b rdy=%b%b, want all 0",
               rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_ovf, busy, req0_ready, req1_ready);
    else passed++;
    apply_reset();
  endtask

  task automatic test_add();
    int lat; logic [15:0] s; logic c, v, rid;
    do_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, lat, s, c, v, rid);
    total++;
    if (lat !== 5) $display("FAIL add_latency: got %0d want 5", lat); else passed++;
    total++;
    if ({s, c, v, rid} !== {16'h2233, 1'b0, 1'b0, 1'b0})
      $display("FAIL add_result: got s=%h c=%b v=%b id=%b want 2233 0 0 0", s, c, v, rid);
    else passed++;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL add_release: got valid=%b busy=%b want 0 0", rsp_valid, busy);
    else passed++;
  endtask

  task automatic test_sub();
    int lat; logic [15:0] s; logic c, v, rid;
    do_op(1'b1, 16'h0005, 16'h0007, 1'b1, lat, s, c, v, rid);
    total++;
    if (lat !== 5 || {s, c, v, rid} !== {16'hFFFE, 1'b0, 1'b0, 1'b1})
      $display("FAIL sub_small: got lat=%0d s=%h c=%b v=%b id=%b want 5 FFFE 0 0 1", lat, s, c, v, rid);
    else passed++;
    do_op(1'b0, 16'h8000, 16'h0001, 1'b1, lat, s, c, v, rid);
    total++;
    if ({s, c, v, rid} !== {16'h7FFF, 1'b1, 1'b1, 1'b0})
      $display("FAIL sub_ovf: got s=%h c=%b v=%b id=%b want 7FFF 1 1 0", s, c, v, rid);
    else passed++;
  endtask

  task automatic test_ripple();
    int lat; logic [15:0] s; logic c, v, rid;
    do_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, lat, s, c, v, rid);
    total++;
    if ({s, c, v} !== {16'h0000, 1'b1, 1'b0})
      $display("FAIL ripple_wrap: got s=%h c=%b v=%b want 0000 1 0", s, c, v);
    else passed++;
    do_op(1'b1, 16'h7FFF, 16'h0001, 1'b0, lat, s, c, v, rid);
    total++;
    if ({s, c, v} !== {16'h8000, 1'b0, 1'b1})
      $display("FAIL ripple_ovf: got s=%h c=%b v=%b want 8000 0 1", s, c, v);
    else passed++;
  endtask

  task automatic test_arbitration();
    int t, gap;
    logic gid, got_rsp, rid;
    logic [15:0] rs;
    apply_reset();
    req0_a = 16'h0100; req0_b = 16'h0001; req0_op = 1'b0;
    req1_a = 16'h0100; req1_b = 16'h0001; req1_op = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    gap = 0;
    for (int g = 0; g < 4; g++) begin
      t = 0;
      while (!(req0_ready | req1_ready) && t < 20) begin @(posedge clk); #1; t++; gap++; end
      gid = req1_ready;
      total++;
      if (t >= 20 || (req0_ready & req1_ready) || gid !== 1'(g % 2))
        $display("FAIL arb_grant%0d: got rdy0=%b rdy1=%b want grant to %0d", g, req0_ready, req1_ready, g % 2);
      else passed++;
      if (g > 0) begin
        total++;
        if (gap !== 6) $display("FAIL arb_spacing%0d: got %0d want 6", g, gap); else passed++;
      end
      @(posedge clk); #1;
      gap = 1;
      total++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
        $display("FAIL arb_pulse%0d: got rdy0=%b rdy1=%b want 0 0", g, req0_ready, req1_ready);
      else passed++;
      got_rsp = 1'b0; rid = 1'b0; rs = '0;
      while (!rsp_valid && t < 40) begin @(posedge clk); #1; t++; gap++; end
      if (rsp_valid) begin got_rsp = 1'b1; rid = rsp_id; rs = rsp_s; end
      total++;
      if (!got_rsp || rid !== gid || rs !== (gid ? 16'h00FF : 16'h0101))
        $display("FAIL arb_rsp%0d: got valid=%b id=%b s=%h want id=%b s=%h", g, got_rsp, rid, rs,
                 gid, gid ? 16'h00FF : 16'h0101);
      else passed++;
      @(posedge clk); #1; gap++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int t;
    logic [15:0] held;
    apply_reset();
    req0_a = 16'h0003; req0_b = 16'h0004; req0_op = 1'b0; req0_valid = 1'b1;
    #1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    t = 0;
    while (!rsp_valid && t < 20) begin @(posedge clk); #1; t++; end
    held = rsp_s;
    total++;
    if (held !== 16'h0007) $display("FAIL bp_result: got %h want 0007", held); else passed++;
    req0_a = 16'h0010; req0_b = 16'h0001; req0_op = 1'b1; req0_valid = 1'b1;
    req1_a = 16'h0020; req1_b = 16'h0002; req1_op = 1'b0; req1_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_s !== 16'h0007 || rsp_id !== 1'b0 || busy !== 1'b1 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0)
        $display("FAIL bp_hold%0d: got valid=%b s=%h id=%b busy=%b rdy=%b%b want 1 0007 0 1 00",
                 k, rsp_valid, rsp_s, rsp_id, busy, req0_ready, req1_ready);
      else passed++;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req1_ready !== 1'b1 || req0_ready !== 1'b0)
      $display("FAIL bp_release: got valid=%b busy=%b rdy0=%b rdy1=%b want 0 0 0 1",
               rsp_valid, busy, req0_ready, req1_ready);
    else passed++;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    total++;
    if (busy !== 1'b1) $display("FAIL bp_next_accept: got busy=%b want 1", busy); else passed++;
    t = 0;
    while (!rsp_valid && t < 20) begin @(posedge clk); #1; t++; end
    total++;
    if (rsp_s !== 16'h0022 || rsp_id !== 1'b1)
      $display("FAIL bp_second: got s=%h id=%b want 0022 1", rsp_s, rsp_id);
    else passed++;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic seen;
    req0_a = 16'h1111; req0_b = 16'h2222; req0_op = 1'b0; req0_valid = 1'b1;
    #1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++;
    if ({rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_ovf, busy} !== 21'd0)
      $display("FAIL mid_reset_values: got valid=%b id=%b s=%h cout=%b ovf=%b busy=%b want all 0",
               rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_ovf, busy);
    else passed++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL mid_reset_no_rsp: got rsp_valid=1 want 0"); else passed++;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL mid_reset_ptr: got rdy0=%b rdy1=%b want 1 0", req0_ready, req1_ready);
    else passed++;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ripple();
    test_arbitration();
    test_backpressure();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
